sfp_acc_buf: RTL
================

// Module: sfp_acc_buf
// PURPOSE
//  Hardware special-function unit that accumulates per-kij partial sums into an output buffer
//  and streams out ReLU'd output-feature-map words. Moves the kij accumulation + ReLU from the
//  bench into RTL. Sits between OFIFO readout and sfp_out in core.
//  Generalised in lane count, psum width, buffer depth, with saturation and selectable ReLU.
// PARAMETERS
//  COL      8   number of psum lanes (array columns)
//  PSUM_BW  16  signed bits per lane
//  DEPTH    16  buffer entries (= len_onij); AW = $clog2(DEPTH) is a localparam
// PORTS
//  clk          in   1            clock, rising edge
//  reset        in   1            asynchronous, active-high; clears all state
//  in_valid     in   1            psum word present
//  in_ready     out  1            unit accepts psum (high in IDLE/ACC)
//  in_addr      in   AW           target entry (o_nij)
//  in_first     in   1            1: overwrite entry with in_data; 0: add to entry
//  in_data      in   COL*PSUM_BW  lane c at bits [c*PSUM_BW +: PSUM_BW], signed
//  drain_start  in   1            request streaming of all DEPTH entries
//  relu_en      in   1            sampled at drain_start; 1: negative lanes -> 0
//  out_valid    out  1            out_data/out_addr valid
//  out_ready    in   1            downstream accepts
//  out_addr     out  AW           entry index of out_data
//  out_data     out  COL*PSUM_BW  result word, same packing as in_data
//  busy         out  1            high in DRAIN
//  ovf          out  1            sticky: any lane saturated since last drain_start
// BEHAVIOUR
//  Reset (async): state=IDLE, all entries=0, out_valid=0, out_addr=0, out_data=0, busy=0,
//   ovf=0, relu latch=0. Reset asserted mid-DRAIN aborts; nothing further emitted.
//  FSM: IDLE -> ACC on first accepted beat; IDLE/ACC -> DRAIN on drain_start; DRAIN -> IDLE
//   after entry DEPTH-1 handshakes.
//  Accept: in_valid & in_ready. Write takes effect at that edge; entry readable next cycle.
//   Back-to-back beats to the same address accumulate correctly (no hazard bubble).
//  Arithmetic: per lane, signed PSUM_BW add; on overflow clamp to +2^(PSUM_BW-1)-1 or
//   -2^(PSUM_BW-1) and set ovf. in_first=1 writes data unchanged (no saturation).
//  drain_start in the same cycle as an accepted beat: beat is committed first, DRAIN begins
//   next cycle. drain_start while busy: ignored. drain_start clears ovf (new beat may re-set).
//  DRAIN: in_ready=0. out_valid rises 1 cycle after drain_start, out_addr=0. Each handshake
//   (out_valid & out_ready) advances out_addr by 1 next cycle and zeroes the drained entry
//   (clear-on-read). out_data/out_addr held stable while out_valid & !out_ready.
//   Full-rate: one word per cycle when out_ready held high; DEPTH words in DEPTH cycles.
//  After last handshake: out_valid=0, busy=0 next cycle, out_addr wraps to 0.
//  ReLU: lane < 0 -> 0 when latched relu_en=1, else passthrough. Applied on output only;
//   buffer contents remain unrectified.
//  in_valid during DRAIN is not accepted (in_ready=0); source must hold.
//  in_addr >= DEPTH (non-power-of-2 DEPTH): beat accepted and discarded.
// TESTING
//  1 Reset: drive garbage then reset=1 async -> all outputs 0, in_ready=1 without clock.
//  2 Accumulate: 9 beats to addr 3, first with in_first=1, all lanes +5 -> drain gives
//    addr 3 lanes = 45, all other addrs = 0, ovf=0.
//  3 ReLU: addr 0 lane0 = -7, lane1 = +7; relu_en=1 -> lane0=0, lane1=7; relu_en=0 -> -7, 7.
//  4 Saturation: PSUM_BW=16, lane = 32000, add +1000 -> 32767 and ovf=1; add -40000 range
//    -> -32768. ovf cleared by next drain_start.
//  5 Backpressure: out_ready toggles 1,0,0,1... -> words in order 0..15, none dropped or
//    duplicated, data stable during stalls; second drain returns all 0.
//  6 Collisions: drain_start with accepted beat -> beat included; reset at word 5 of DRAIN
//    -> out_valid=0 immediately, next drain returns zeros.

Source files
------------

// File: rtl/sfp_acc_buf.sv
// Accumulates per-kij partial sums into a DEPTH-entry buffer with saturating per-lane adds,
// then streams the entries out (optionally ReLU'd) under valid/ready, clearing each one as it drains.
module sfp_acc_buf #(
    parameter int COL     = 8,
    parameter int PSUM_BW = 16,
    parameter int DEPTH   = 16,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic                   in_first,
    input  logic [COL*PSUM_BW-1:0] in_data,
    input  logic                   drain_start,
    input  logic                   relu_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_addr,
    output logic [COL*PSUM_BW-1:0] out_data,
    output logic                   busy,
    output logic                   ovf
);

    localparam int W = COL * PSUM_BW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      mem_q [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              relu_q, relu_d;
    logic              ovf_q, ovf_d;

    logic              addr_ok;
    logic              beat_acc, beat_wr, drain_go, out_hs, last_word;
    logic [W-1:0]      acc_word;
    logic              acc_sat;
    logic [W-1:0]      rd_word;
    logic [PSUM_BW-1:0] lane_a, lane_b;
    logic [PSUM_BW:0]   lane_s;

    // Out-of-range addresses only exist when DEPTH is not a power of two.
    generate
        if (DEPTH == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, in_addr} < (AW+1)'(DEPTH));
        end
    endgenerate

    assign in_ready  = (state_q != S_DRAIN);
    assign beat_acc  = in_valid & in_ready;
    assign beat_wr   = beat_acc & addr_ok;
    assign drain_go  = drain_start & in_ready;
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = out_valid;
    assign out_hs    = out_valid & out_ready;
    assign last_word = (ptr_q == AW'(DEPTH - 1));
    assign out_addr  = ptr_q;
    assign ovf       = ovf_q;
    assign rd_word   = mem_q[ptr_q];

    // Saturating add against the registered entry; back-to-back beats see the previous write.
    always_comb begin
        acc_word = '0;
        acc_sat  = 1'b0;
        lane_a   = '0;
        lane_b   = '0;
        lane_s   = '0;
        for (int c = 0; c < COL; c++) begin
            lane_a = mem_q[in_addr][c*PSUM_BW +: PSUM_BW];
            lane_b = in_data[c*PSUM_BW +: PSUM_BW];
            lane_s = {lane_a[PSUM_BW-1], lane_a} + {lane_b[PSUM_BW-1], lane_b};
            if (lane_s[PSUM_BW] != lane_s[PSUM_BW-1]) begin
                acc_sat = 1'b1;
                acc_word[c*PSUM_BW +: PSUM_BW] = lane_s[PSUM_BW] ?
                    {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
            end else begin
                acc_word[c*PSUM_BW +: PSUM_BW] = lane_s[PSUM_BW-1:0];
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int c = 0; c < COL; c++) begin
                if (relu_q && rd_word[c*PSUM_BW + PSUM_BW - 1]) begin
                    out_data[c*PSUM_BW +: PSUM_BW] = '0;
                end else begin
                    out_data[c*PSUM_BW +: PSUM_BW] = rd_word[c*PSUM_BW +: PSUM_BW];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        relu_d  = relu_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (beat_acc) begin
                    state_d = S_ACC;
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    if (last_word) begin
                        state_d = S_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // A beat in the drain_start cycle is committed first, so its saturation survives the clear.
        if (drain_go) begin
            state_d = S_DRAIN;
            ptr_d   = '0;
            relu_d  = relu_en;
            ovf_d   = 1'b0;
        end
        if (beat_wr && !in_first && acc_sat) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            relu_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            relu_q  <= relu_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (beat_wr) begin
            mem_q[in_addr] <= in_first ? in_data : acc_word;
        end else if (out_hs) begin
            mem_q[ptr_q] <= '0;
        end
    end

endmodule
